// File: rtl/reg_bank_onehot.sv
// Eight-entry register bank addressed by a one-hot read/write select vector, with sticky select-error tracking.
// Latency: a read returns dout one clock after the select; writes land at the select edge.
// Backpressure: none; one decision per cycle, and dout_vld pulses for each legal read.
module reg_bank_onehot #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2*NREG-1:0] sel,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout,
    output logic              dout_vld,
    output logic              dout_init,
    output logic [NREG-1:0]   wr_map,
    output logic              err,
    input  logic              err_clr,
    output logic [3:0]        err_cnt
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   regs [NREG];
    logic            sel_ok;
    logic            sel_bad;
    logic [IW-1:0]   idx;

    // Each register k owns the pair sel[2N-1-2k] (read) and sel[2N-2-2k] (write).
    always_comb begin
        sel_ok  = en && $onehot(sel);
        sel_bad = en && !$onehot(sel);
        idx     = '0;
        for (int k = 0; k < NREG; k++) begin
            if (sel[2*NREG-1-2*k] || sel[2*NREG-2-2*k]) begin
                idx = IW'(k);
            end
        end
        state_nxt = IDLE;
        if (sel_bad) begin
            state_nxt = ERR;
        end else if (sel_ok) begin
            state_nxt = (sel[2*NREG-1-2*int'(idx)]) ? RD : WR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dout      <= '0;
            dout_init <= 1'b0;
            wr_map    <= '0;
            err       <= 1'b0;
            err_cnt   <= 4'd0;
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state_nxt)
                RD: begin
                    dout      <= regs[idx];
                    dout_init <= wr_map[idx];
                end
                WR: begin
                    regs[idx]   <= din;
                    wr_map[idx] <= 1'b1;
                end
                default: ;
            endcase
            // A malformed select in the same cycle as err_clr restarts the count at one.
            if (sel_bad) begin
                err <= 1'b1;
                if (err_clr) begin
                    err_cnt <= 4'd1;
                end else if (err_cnt != 4'd15) begin
                    err_cnt <= err_cnt + 4'd1;
                end
            end else if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= 4'd0;
            end
        end
    end

    assign dout_vld = (state == RD);

    sel_known_a: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(sel));

endmodule

// File: tb/tb_reg_bank_onehot.sv
// Directed bench for reg_bank_onehot; reads push expected data to a queue that a negedge monitor drains.
module tb_reg_bank_onehot;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] sel;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_init;
    logic [7:0]  wr_map;
    logic        err;
    logic        err_clr;
    logic [3:0]  err_cnt;

    int checks;
    int errors;

    logic [16:0] exp_q[$];
    logic [15:0] m_regs [8];
    logic [7:0]  m_wm;

    reg_bank_onehot #(.DW(16), .NREG(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_init(dout_init),
        .wr_map   (wr_map),
        .err      (err),
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; returns at posedge+1 with the result registered.
    task automatic op(input logic e, input logic [15:0] s, input logic [15:0] d, input logic c);
        en      = e;
        sel     = s;
        din     = d;
        err_clr = c;
        if (e && $countones(s) == 1) begin
            for (int k = 0; k < 8; k++) begin
                if (s[15-2*k]) exp_q.push_back({m_wm[k], m_regs[k]});
                if (s[14-2*k]) begin
                    m_regs[k] = d;
                    m_wm[k]   = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_regs[k] = 16'h0000;
        m_wm = 8'h00;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && dout_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: dout=%h init=%b with no read pending", dout, dout_init);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({dout_init, dout} !== e) begin
                    errors++;
                    $display("FAIL read_data: got init=%b dout=%h expected init=%b dout=%h",
                             dout_init, dout, e[16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        sel     = 16'h0000;
        din     = 16'h0000;
        err_clr = 1'b0;
        model_reset();
        #1;
        chk("init_dout", 32'(dout), 32'h0);
        chk("init_vld", 32'(dout_vld), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Uninitialised read of reg7
        op(1'b1, 16'h0002, 16'h0000, 1'b0);
        chk("uninit_dout", 32'(dout), 32'h0);

        // Write reg0 then read it back on the next cycle
        op(1'b1, 16'h4000, 16'hA5A5, 1'b0);
        chk("wr_no_vld", 32'(dout_vld), 32'h0);
        op(1'b1, 16'h8000, 16'h0000, 1'b0);
        chk("wr_map_01", 32'(wr_map), 32'h01);
        op(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("dout_hold", 32'(dout), 32'hA5A5);

        // en=0 must block both writes and reads
        op(1'b0, 16'h1000, 16'hFFFF, 1'b0);
        op(1'b0, 16'h2000, 16'h0000, 1'b0);
        chk("en0_wr_map", 32'(wr_map), 32'h01);
        chk("en0_vld", 32'(dout_vld), 32'h0);

        // Malformed selects
        op(1'b1, 16'hC000, 16'h1111, 1'b0);
        op(1'b1, 16'h0000, 16'h2222, 1'b0);
        chk("mal_err", 32'(err), 32'h1);
        chk("mal_cnt2", 32'(err_cnt), 32'h2);
        chk("mal_dout", 32'(dout), 32'hA5A5);
        chk("mal_vld", 32'(dout_vld), 32'h0);
        chk("mal_wr_map", 32'(wr_map), 32'h01);
        op(1'b1, 16'h8000, 16'h0000, 1'b0);
        for (int i = 0; i < 15; i++) op(1'b1, 16'hFFFF, 16'h0000, 1'b0);
        chk("mal_sat15", 32'(err_cnt), 32'hF);

        // Clear colliding with a malformed select, then clear alone
        op(1'b1, 16'h0003, 16'h0000, 1'b1);
        chk("clr_col_err", 32'(err), 32'h1);
        chk("clr_col_cnt", 32'(err_cnt), 32'h1);
        op(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_cnt", 32'(err_cnt), 32'h0);

        // Sweep: write k*0x1111 to every register, read back 7..0 back-to-back
        for (int k = 0; k < 8; k++) op(1'b1, 16'(1 << (14 - 2*k)), 16'(k * 16'h1111), 1'b0);
        chk("sweep_wr_map", 32'(wr_map), 32'hFF);
        for (int k = 7; k >= 0; k--) begin
            op(1'b1, 16'(1 << (15 - 2*k)), 16'h0000, 1'b0);
            chk("sweep_vld", 32'(dout_vld), 32'h1);
        end
        op(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("sweep_end_vld", 32'(dout_vld), 32'h0);
        chk("sweep_drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-cycle with a read in flight
        op(1'b1, 16'h0030, 16'h0000, 1'b0);
        op(1'b1, 16'h0200, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld", 32'(dout_vld), 32'h0);
        chk("rst_wr_map", 32'(wr_map), 32'h00);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_cnt", 32'(err_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b0;
        op(1'b1, 16'h0800, 16'h0000, 1'b0);
        op(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("final_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
